rx_word_align: RTL and testbench
================================

// Module: rx_word_align
// PURPOSE
//  Word-alignment controller for the tree deserializer's parallel output, in the divided-clock domain.
//  Hunts for a training pattern one bit-slip per cycle, then verifies the candidate alignment before locking.
//  Once locked, emits aligned words and drops lock after repeated training mismatches.
//  Sits between the deserializer's dout bus and the lane/link logic; the lane FSM drives train/en.
// PARAMETERS
//  STAGES      5   deserializer depth; WIDTH = 2**STAGES (package constant)
//  LOCK_CNT    4   consecutive pattern matches (incl. first) needed to declare lock, >=1
//  UNLOCK_CNT  2   consecutive mismatches while locked and training that drop lock, >=1
// PORTS
//  clk         in   1          divided word clock (deserializer's slowest stage clock)
//  rst         in   1          synchronous reset, active-high
//  en          in   1          word strobe; low = hold all state, dout_valid=0
//  train       in   1          1 = link is sending pattern; checks enabled
//  din         in   WIDTH      raw deserializer word; din[0] = earliest bit
//  pattern     in   WIDTH      training word, quasi-static (change only while rst or !en)
//  dout        out  WIDTH      aligned word, dout[0] = earliest bit
//  dout_valid  out  1          dout is aligned data
//  locked      out  1          FSM in LOCKED
//  shift       out  STAGES     current bit-slip, 0..WIDTH-1
//  err_cnt     out  16         [RX_ALIGN_ERR_CNT_EN only] saturating bit-error count
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=SEARCH, shift=0, prev=0, match/miss counters=0,
//    dout=0, dout_valid=0, locked=0, err_cnt=0. Reset mid-lock aborts immediately.
//  - All state advances only on cycles with en=1; with en=0 everything holds except dout_valid<=0.
//  - prev <= din on every en cycle. aligned = ({din,prev} >> shift)[WIDTH-1:0] (combinational).
//  - dout <= aligned; dout_valid <= en & locked. Latency: din word n appears on dout at cycle n+1.
//  - hit = (aligned == pattern). Shift changes take effect on the next en cycle's compare.
//  - FSM (states in package enum):
//    SEARCH: train=0 -> hold. hit -> VERIFY, match_cnt=1 (LOCK_CNT=1 -> LOCKED directly).
//            miss -> shift = shift+1, wrapping WIDTH-1 -> 0.
//    VERIFY: train=0 -> back to SEARCH, shift unchanged. hit -> match_cnt++; reaching LOCK_CNT -> LOCKED.
//            miss -> SEARCH, shift+1 (wraps), match_cnt=0.
//    LOCKED: train=0 -> no checking, miss_cnt=0. train=1 & hit -> miss_cnt=0.
//            train=1 & miss -> miss_cnt++; reaching UNLOCK_CNT -> SEARCH, shift+1 (wraps), locked=0 next cycle.
//  - locked is registered: high on the first cycle after VERIFY->LOCKED.
//  - Periodic patterns can match at several shifts; the first match found from the current shift is accepted.
//  - Counters are sized $clog2(max(LOCK_CNT,UNLOCK_CNT)+1) and never wrap.
// CONFIGURATION
//  `RX_ALIGN_ERR_CNT_EN defined: err_cnt port present.
//    - In LOCKED with train=1, adds popcount(aligned ^ pattern) each en cycle.
//    - Saturates at 16'hFFFF; cleared only by rst.
//  Undefined: no err_cnt port, no popcount logic; all other behaviour identical.
// STRUCTURE
//  - rx_align_pkg: WIDTH/STAGES localparams, typedef enum logic [1:0] {SEARCH,VERIFY,LOCKED} align_state_t,
//    typedef logic [WIDTH-1:0] word_t.
//  - Sub-module rx_align_shift: combinational {din,prev} >> shift selector (WIDTH-bit out), reused by bench model.
//  - Top holds FSM, counters, prev/dout registers, optional error counter.
// TESTING
//  1. pattern=32'hA5C3_0F1E, stream offset 7 bits, train=1 -> 7 slips, locked after 7+4=11 en cycles, shift=7, dout==pattern.
//  2. Offset 31 -> shift walks 0..31 without error; lock at shift=31. Slip from 31 wraps to 0.
//  3. Locked, train=1, inject 1 corrupted word -> stays locked.
//     2 consecutive corrupted words -> SEARCH, shift+1, locked=0 one cycle later.
//  4. Locked, train=0, random data -> never unlocks; dout equals stream realigned by shift, 1-cycle latency.
//  5. en toggled 1/0 randomly during search -> slips/lock count only en cycles.
//     rst asserted while locked -> all outputs 0 next cycle.
//  6. With RX_ALIGN_ERR_CNT_EN: locked, 3 single-bit-error words -> err_cnt=3.
//     Force 16'hFFFE then 2 more errors -> err_cnt=16'hFFFF.

Source files
------------

// File: rtl/rx_align_pkg.sv
// Shared constants and types for the rx word-alignment slice.
// Deserializer depth and word width live here so that every block agrees on them.
package rx_align_pkg;

  localparam int STAGES = 5;
  localparam int WIDTH  = 2 ** STAGES;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } align_state_t;

  typedef logic [WIDTH-1:0] word_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Number of set bits in a word. STAGES+1 bits are enough to hold WIDTH.
  function automatic logic [STAGES:0] popcount(input word_t w);
    logic [STAGES:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + {{STAGES{1'b0}}, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rx_align_shift.sv
// Bit-slip selector: picks WIDTH consecutive stream bits starting at 'shift'
// from the previous word (earlier bits) followed by the current word.
module rx_align_shift
  import rx_align_pkg::*;
(
  input  logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  prev,
  input  logic [STAGES-1:0] shift,
  output logic [WIDTH-1:0]  aligned
);

  assign aligned = WIDTH'({din, prev} >> shift);

endmodule

// File: rtl/rx_word_align.sv
// Word-alignment controller: hunts for the training word one bit-slip per word,
// verifies it, then holds lock. Optional error counter enabled by `RX_ALIGN_ERR_CNT_EN.
module rx_word_align
  import rx_align_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              train,
  input  logic [WIDTH-1:0]  din,
  input  logic [WIDTH-1:0]  pattern,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              locked,
  output logic [STAGES-1:0] shift
`ifdef RX_ALIGN_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam int CNT_W = $clog2(max_int(LOCK_CNT, UNLOCK_CNT) + 1);
  localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] UNLOCK_LIM = CNT_W'(UNLOCK_CNT);

  align_state_t      state, state_next;
  logic [STAGES-1:0] shift_next;
  logic [CNT_W-1:0]  match_cnt, match_next, match_inc;
  logic [CNT_W-1:0]  miss_cnt, miss_next, miss_inc;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  aligned;
  logic              hit;

  rx_align_shift u_shift (
    .din     (din),
    .prev    (prev),
    .shift   (shift),
    .aligned (aligned)
  );

  assign hit       = (aligned == pattern);
  assign match_inc = match_cnt + 1'b1;
  assign miss_inc  = miss_cnt + 1'b1;

  // Counters stop at their limits because reaching a limit always changes state.
  always_comb begin
    state_next = state;
    shift_next = shift;
    match_next = match_cnt;
    miss_next  = miss_cnt;
    unique case (state)
      SEARCH: begin
        if (train) begin
          if (hit) begin
            if (LOCK_CNT == 1) begin
              state_next = LOCKED;
              match_next = '0;
            end else begin
              state_next = VERIFY;
              match_next = CNT_W'(1);
            end
          end else begin
            shift_next = shift + 1'b1;
          end
        end
      end
      VERIFY: begin
        if (!train) begin
          state_next = SEARCH;
          match_next = '0;
        end else if (hit) begin
          if (match_inc == LOCK_LIM) begin
            state_next = LOCKED;
            match_next = '0;
          end else begin
            match_next = match_inc;
          end
        end else begin
          state_next = SEARCH;
          shift_next = shift + 1'b1;
          match_next = '0;
        end
      end
      LOCKED: begin
        if (!train || hit) begin
          miss_next = '0;
        end else if (miss_inc == UNLOCK_LIM) begin
          state_next = SEARCH;
          shift_next = shift + 1'b1;
          miss_next  = '0;
        end else begin
          miss_next = miss_inc;
        end
      end
      default: begin
        state_next = SEARCH;
        match_next = '0;
        miss_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      shift      <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      prev       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      dout_valid <= en & locked;
      if (en) begin
        state     <= state_next;
        shift     <= shift_next;
        match_cnt <= match_next;
        miss_cnt  <= miss_next;
        prev      <= din;
        dout      <= aligned;
        locked    <= (state_next == LOCKED);
      end
    end
  end

`ifdef RX_ALIGN_ERR_CNT_EN
  logic [16:0] err_sum;

  assign err_sum = {1'b0, err_cnt} + 17'(popcount(aligned ^ pattern));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (en && train && (state == LOCKED)) begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_rx_word_align.sv
// Self-checking bench for rx_word_align: directed lock/unlock scenarios plus
// randomized streams compared every cycle against a stream-level reference model.
module tb_rx_word_align;
  import rx_align_pkg::*;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              train = 1'b0;
  word_t             din = '0;
  word_t             pattern = '0;
  word_t             dout;
  logic              dout_valid;
  logic              locked;
  logic [STAGES-1:0] shift;
`ifdef RX_ALIGN_ERR_CNT_EN
  logic [15:0]       err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rx_word_align #(.LOCK_CNT(LOCK_N), .UNLOCK_CNT(UNLOCK_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .train      (train),
    .din        (din),
    .pattern    (pattern),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .shift      (shift)
`ifdef RX_ALIGN_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: tracks the bit stream window, the current slip and how many
  // consecutive hits/misses have been seen, directly from the alignment rules.
  bit    model_ok = 1'b0;
  word_t m_prev;
  int    m_shift;
  bit    m_in_lock;
  int    m_run;
  int    m_miss;
  word_t exp_dout;
  bit    exp_valid;
  int    m_err;

  always @(posedge clk) begin
    logic [2*WIDTH-1:0] window;
    word_t al;
    bit    was_locked;
    if (rst) begin
      model_ok  = 1'b1;
      m_prev    = '0;
      m_shift   = 0;
      m_in_lock = 1'b0;
      m_run     = 0;
      m_miss    = 0;
      exp_dout  = '0;
      exp_valid = 1'b0;
      m_err     = 0;
    end else if (model_ok) begin
      if (!en) begin
        exp_valid = 1'b0;
      end else begin
        window     = {din, m_prev} >> m_shift;
        al         = window[WIDTH-1:0];
        was_locked = m_in_lock;
        exp_valid  = was_locked;
        exp_dout   = al;
        m_prev     = din;
        if (was_locked && train)
          m_err = (m_err + $countones(al ^ pattern) > 65535) ? 65535 : m_err + $countones(al ^ pattern);
        if (was_locked) begin
          if (!train || al == pattern) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss >= UNLOCK_N) begin
              m_in_lock = 1'b0;
              m_miss    = 0;
              m_run     = 0;
              m_shift   = (m_shift + 1) % WIDTH;
            end
          end
        end else if (!train) begin
          m_run = 0;
        end else if (al == pattern) begin
          m_run++;
          if (m_run >= LOCK_N) begin
            m_in_lock = 1'b1;
            m_run     = 0;
          end
        end else begin
          m_run   = 0;
          m_shift = (m_shift + 1) % WIDTH;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("locked", 32'(locked), 32'(m_in_lock));
      checkOutput("shift", 32'(shift), 32'(m_shift));
      checkOutput("dout_valid", 32'(dout_valid), 32'(exp_valid));
      checkOutput("dout", dout, exp_dout);
`ifdef RX_ALIGN_ERR_CNT_EN
      checkOutput("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
    end
  end

  task automatic applyStimulus(input logic e, input logic t, input word_t d);
    en    = e;
    train = t;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input word_t pat);
    rst     = 1'b1;
    pattern = pat;
    applyStimulus(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  function automatic word_t rotl(input word_t w, input int n);
    int k;
    k = n % WIDTH;
    return (k == 0) ? w : ((w << k) | (w >> (WIDTH - k)));
  endfunction

  task automatic waitLock(input string name, input word_t d, input int budget);
    for (int i = 0; i < budget && !locked; i++) applyStimulus(1'b1, 1'b1, d);
    checkOutput(name, 32'(locked), 32'd1);
  endtask

  localparam word_t PAT = 32'hA5C3_0F1E;

  initial begin
    word_t s7, s31, rp;
    int    n_en, off;
    bit    e;

    s7  = rotl(PAT, 7);
    s31 = rotl(PAT, 31);

    rst = 1'b1;
    pattern = PAT;
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, s7);
    checkOutput("reset_locked", 32'(locked), 32'd0);
    checkOutput("reset_valid", 32'(dout_valid), 32'd0);
    checkOutput("reset_shift", 32'(shift), 32'd0);
    checkOutput("reset_dout", dout, 32'd0);
    rst = 1'b0;

    $display("[TB] offset 7 lock");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, s7);
    checkOutput("off7_not_yet_locked", 32'(locked), 32'd0);
    applyStimulus(1'b1, 1'b1, s7);
    checkOutput("off7_locked", 32'(locked), 32'd1);
    checkOutput("off7_shift", 32'(shift), 32'd7);
    applyStimulus(1'b1, 1'b1, s7);
    checkOutput("off7_valid", 32'(dout_valid), 32'd1);
    checkOutput("off7_dout", dout, PAT);

    $display("[TB] single and double corruption");
    applyStimulus(1'b1, 1'b1, s7 ^ 32'h1);
    applyStimulus(1'b1, 1'b1, s7);
    applyStimulus(1'b1, 1'b1, s7);
    checkOutput("one_error_still_locked", 32'(locked), 32'd1);
    applyStimulus(1'b1, 1'b1, s7 ^ 32'h1);
    applyStimulus(1'b1, 1'b1, s7 ^ 32'h1);
    checkOutput("two_errors_unlock", 32'(locked), 32'd0);
    checkOutput("two_errors_shift", 32'(shift), 32'd8);
    waitLock("relock_off7", s7, 100);

    $display("[TB] offset 31 lock and wrap");
    doReset(PAT);
    for (int i = 0; i < 34; i++) applyStimulus(1'b1, 1'b1, s31);
    checkOutput("off31_not_yet_locked", 32'(locked), 32'd0);
    applyStimulus(1'b1, 1'b1, s31);
    checkOutput("off31_locked", 32'(locked), 32'd1);
    checkOutput("off31_shift", 32'(shift), 32'd31);
    applyStimulus(1'b1, 1'b1, s31 ^ 32'h1);
    applyStimulus(1'b1, 1'b1, s31 ^ 32'h1);
    checkOutput("off31_unlock", 32'(locked), 32'd0);
    checkOutput("off31_wrap_shift", 32'(shift), 32'd0);
    waitLock("relock_off31", s31, 100);

    $display("[TB] locked with train low");
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b0, $urandom);
    checkOutput("train_low_keeps_lock", 32'(locked), 32'd1);

    $display("[TB] gapped enable");
    doReset(PAT);
    n_en = 0;
    for (int i = 0; i < 200 && !locked; i++) begin
      e = ($urandom_range(0, 1) == 1);
      applyStimulus(e, 1'b1, s7);
      if (e) n_en++;
    end
    checkOutput("gapped_locked", 32'(locked), 32'd1);
    checkOutput("gapped_en_cycles", 32'(n_en), 32'd11);
    checkOutput("gapped_shift", 32'(shift), 32'd7);
    applyStimulus(1'b1, 1'b1, s7);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, s7);
    rst = 1'b0;
    checkOutput("midlock_reset_locked", 32'(locked), 32'd0);
    checkOutput("midlock_reset_valid", 32'(dout_valid), 32'd0);
    checkOutput("midlock_reset_shift", 32'(shift), 32'd0);
    checkOutput("midlock_reset_dout", dout, 32'd0);

`ifdef RX_ALIGN_ERR_CNT_EN
    $display("[TB] error counter");
    doReset(PAT);
    waitLock("err_lock", s7, 50);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, s7 ^ 32'h1);
      applyStimulus(1'b1, 1'b1, s7);
    end
    checkOutput("err_cnt_three", 32'(err_cnt), 32'd3);
    for (int i = 0; i < 9400; i++) begin
      applyStimulus(1'b1, 1'b1, s7 ^ 32'h7F);
      applyStimulus(1'b1, 1'b1, s7);
    end
    checkOutput("err_cnt_saturated", 32'(err_cnt), 32'h0000_FFFF);
    checkOutput("err_cnt_still_locked", 32'(locked), 32'd1);
`endif

    $display("[TB] randomized streams");
    for (int ep = 0; ep < 20; ep++) begin
      rp  = $urandom;
      off = $urandom_range(0, WIDTH - 1);
      doReset(rp);
      for (int i = 0; i < 150; i++) begin
        e = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 9) == 0)
          applyStimulus(e, 1'b0, $urandom);
        else if ($urandom_range(0, 15) == 0)
          applyStimulus(e, 1'b1, rotl(rp, off) ^ (32'h1 << $urandom_range(0, WIDTH - 1)));
        else
          applyStimulus(e, 1'b1, rotl(rp, off));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
